// File: rtl/tcm_ctrl_pkg.sv
// rtl/tcm_ctrl_pkg.sv - shared state and response-type encodings for tcm_ctrl
`timescale 1ns/1ps
package tcm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RSP_LIVE = 2'd1,
    RSP_HELD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RSP_READ  = 2'd0,
    RSP_WRITE = 2'd1,
    RSP_ERR   = 2'd2
  } rsp_type_t;

endpackage

// File: rtl/tcm_ctrl.sv
// rtl/tcm_ctrl.sv - single-outstanding command front end for a 1-cycle-latency TCM SRAM
`timescale 1ns/1ps
module tcm_ctrl
  import tcm_ctrl_pkg::*;
#(
  parameter int DP = 512,
  parameter int DW = 32,
  parameter int MW = 4,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_read,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [MW-1:0] cmd_wmask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  output logic [MW-1:0] ram_wem,
  input  logic [DW-1:0] ram_dout
);

  state_t        state_q, state_d;
  rsp_type_t     rsp_type_q, rsp_type_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          accept;
  logic          unused_addr_lsbs;

  assign word_idx         = {2'b00, cmd_addr[AW-1:2]};
  assign unused_addr_lsbs = ^cmd_addr[1:0];
  assign in_range         = word_idx < AW'(DP);

  assign rsp_valid = (state_q != IDLE);
  assign cmd_ready = (state_q == IDLE) | (rsp_valid & rsp_ready);
  assign accept    = cmd_valid & cmd_ready;

  assign ram_addr = word_idx;
  assign ram_din  = cmd_wdata;
  assign ram_we   = accept & ~cmd_read & in_range;
  assign ram_wem  = ram_we ? cmd_wmask : '0;

  // Read data comes straight from the SRAM on the cycle after the access,
  // and from the hold register once the response has been stalled.
  assign rsp_err   = rsp_valid & (rsp_type_q == RSP_ERR);
  assign rsp_rdata = (rsp_valid && rsp_type_q == RSP_READ)
                   ? ((state_q == RSP_HELD) ? hold_q : ram_dout)
                   : '0;

  always_comb begin
    state_d    = state_q;
    rsp_type_d = rsp_type_q;
    hold_d     = hold_q;

    if (accept) begin
      if (!in_range) begin
        rsp_type_d = RSP_ERR;
      end else if (cmd_read) begin
        rsp_type_d = RSP_READ;
      end else begin
        rsp_type_d = RSP_WRITE;
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) state_d = RSP_LIVE;
      end
      RSP_LIVE: begin
        if (rsp_ready) begin
          state_d = accept ? RSP_LIVE : IDLE;
        end else begin
          // Freeze the data now so later SRAM writes cannot disturb it.
          state_d = RSP_HELD;
          hold_d  = ram_dout;
        end
      end
      RSP_HELD: begin
        if (rsp_ready) state_d = accept ? RSP_LIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rsp_type_q <= RSP_WRITE;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      rsp_type_q <= rsp_type_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_tcm_ctrl.sv
// tb/tb_tcm_ctrl.sv - vector table plus scoreboard bench for tcm_ctrl with a behavioural SRAM
`timescale 1ns/1ps
module tb_tcm_ctrl;

  localparam int DP = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_read = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wmask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [3:0]  ram_wem;
  logic [31:0] ram_dout;

  tcm_ctrl #(.DP(DP), .DW(32), .MW(4), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_wem(ram_wem),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // SRAM model: low address bits only, so a stray out-of-range write would alias.
  logic [31:0] mem [0:DP-1];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_wem[b]) mem[ram_addr[8:0]][8*b +: 8] <= ram_din[8*b +: 8];
    end
    ram_dout <= mem[ram_addr[8:0]];
  end

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  vec_t vecs[17];
  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic seen = 1'b0;
  logic oob_we = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, input logic [31:0] er, input logic ee,
                      output int waits);
    exp_t e;
    int   n;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wmask = mask;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    waits = n;
    if (!cmd_ready) begin
      timeout("cmd_accept");
    end else begin
      e.rdata = er;
      e.err   = ee;
      e.cyc   = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) timeout("rsp_drain");
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (ram_we && ram_addr >= 32'(DP)) oob_we = 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      seen = 1'b0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        timeout("unexpected_rsp");
      end else begin
        if (!seen) begin
          check("rsp_latency_cycle", 32'(cyc), 32'(exp_q[0].cyc));
          seen = 1'b1;
        end
        if (rsp_ready) begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int w;

    vecs[0]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0020, 32'h0000_AA00, 4'h2, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0020, 32'h0,         4'h0, 32'h1122_AA44, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0023, 32'h0,         4'h0, 32'h1122_AA44, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0800, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0800, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_07FC, 32'hA5A5_5A5A, 4'hF, 32'h0,         1'b0};
    vecs[11] = '{1'b1, 32'h0000_07FC, 32'h0,         4'h0, 32'hA5A5_5A5A, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0017, 32'h1234_5678, 4'h9, 32'h0,         1'b0};
    vecs[13] = '{1'b1, 32'h0000_0014, 32'h0,         4'h0, 32'h1200_0078, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_0030, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
    vecs[15] = '{1'b1, 32'h0000_0030, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[16] = '{1'b1, 32'hFFFF_FFF0, 32'h0,         4'h0, 32'h0,         1'b1};

    for (int i = 0; i < DP; i++) mem[i] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    check("reset_ram_we", {31'b0, ram_we}, 32'h0);
    check("reset_ram_wem", {28'b0, ram_wem}, 32'h0);
    rst = 1'b0;
    check("post_reset_cmd_ready", {31'b0, cmd_ready}, 32'h1);

    rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
           vecs[i].exp_rdata, vecs[i].exp_err, w);
      if (i == 0) check("first_cmd_no_wait", 32'(w), 32'h0);
    end
    drain();

    // Stalled read keeps its data while the SRAM word changes underneath.
    rsp_ready = 1'b0;
    send(1'b1, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) mem[4] = 32'h0BAD_F00D;
      check("held_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      check("held_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("held_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain();

    for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 32'(i * 4), 32'h0, 4'h0, 32'h1000_0000 + 32'(i) * 32'h0000_0101, 1'b0, w);
      check("b2b_no_stall", 32'(w), 32'h0);
    end
    drain();

    // Reset while a response is stalled discards it.
    rsp_ready = 1'b0;
    send(1'b1, 32'h0000_0020, 32'h0, 4'h0, 32'h1122_AA44, 1'b0, w);
    @(negedge clk);
    check("pre_reset_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("async_reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    send(1'b1, 32'h0000_0020, 32'h0, 4'h0, 32'h1122_AA44, 1'b0, w);
    check("after_reset_no_wait", 32'(w), 32'h0);
    drain();

    check("oob_ram_we_seen", {31'b0, oob_we}, 32'h0);
    check("edge_word_intact", mem[511], 32'hA5A5_5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
